// File: rtl/data_structures.sv
// Shared types for the out-of-order core: register/ROB widths, functional-unit
// opcodes and the load/store unit state encoding.
package data_structures;

  localparam int GPR_SIZE     = 64;
  localparam int ROB_IDX_SIZE = 5;

  typedef enum logic [1:0] {
    FU_OP_NOP  = 2'd0,
    FU_OP_LDUR = 2'd1,
    FU_OP_STUR = 2'd2,
    FU_OP_ALU  = 2'd3
  } fu_op_t;

  typedef enum logic [2:0] {
    LS_IDLE  = 3'd0,
    LS_REQ   = 3'd1,
    LS_WAIT  = 3'd2,
    LS_RESP  = 3'd3,
    LS_DRAIN = 3'd4
  } ls_state_t;

  // All LDUR/STUR accesses are 64-bit and must sit on an 8-byte boundary.
  function automatic logic is_misaligned(input logic [GPR_SIZE-1:0] addr);
    return addr[2:0] != 3'b000;
  endfunction

endpackage

// File: rtl/ls_unit.sv
// Single-entry load/store unit: takes one LDUR/STUR from the reservation
// station, runs one memory transaction and reports the result to the ROB.
module ls_unit
  import data_structures::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    in_clk,
  input  logic                    in_rst_n,
  input  logic                    in_rs_start,
  input  fu_op_t                  in_rs_op,
  input  logic [GPR_SIZE-1:0]     in_rs_val_a,
  input  logic [GPR_SIZE-1:0]     in_rs_val_b,
  input  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
  output logic                    out_rs_ready,
  output logic                    out_mem_req_valid,
  input  logic                    in_mem_req_ready,
  output logic                    out_mem_we,
  output logic [GPR_SIZE-1:0]     out_mem_addr,
  output logic [GPR_SIZE-1:0]     out_mem_wdata,
  input  logic                    in_mem_resp_valid,
  input  logic [GPR_SIZE-1:0]     in_mem_rdata,
  input  logic                    in_flush,
  output logic                    out_rob_done,
  output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
  output logic [GPR_SIZE-1:0]     out_rob_value,
  output logic                    out_rob_fault
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  ls_state_t               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    init_q;
  fu_op_t                  op_q, op_d;
  logic [GPR_SIZE-1:0]     addr_q, addr_d;
  logic [GPR_SIZE-1:0]     wdata_q, wdata_d;
  logic [ROB_IDX_SIZE-1:0] tag_q, tag_d;
  logic [GPR_SIZE-1:0]     value_q, value_d;
  logic                    fault_q, fault_d;

  logic                    rs_ready;
  logic                    accept;
  logic                    is_store;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    timed_out;
  logic                    req_vld;
  logic                    done;

  always_comb begin
    rs_ready  = init_q && (state_q == LS_IDLE) && !in_flush;
    accept    = in_rs_start && rs_ready;
    is_store  = (op_q == FU_OP_STUR);
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    timed_out = (cnt_inc == CNT_MAX);

    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tag_d   = tag_q;
    value_d = value_q;
    fault_d = fault_q;

    unique case (state_q)
      LS_IDLE: begin
        if (accept) begin
          op_d    = in_rs_op;
          addr_d  = in_rs_val_a;
          wdata_d = in_rs_val_b;
          tag_d   = in_rs_dst_rob_index;
          cnt_d   = '0;
          value_d = '0;
          if (is_misaligned(in_rs_val_a)) begin
            state_d = LS_RESP;
            fault_d = 1'b1;
          end else begin
            state_d = LS_REQ;
            fault_d = 1'b0;
          end
        end
      end
      LS_REQ: begin
        // Once memory has taken the request its response must still be absorbed.
        if (in_mem_req_ready) begin
          state_d = in_flush ? LS_DRAIN : LS_WAIT;
          cnt_d   = '0;
        end else if (in_flush) begin
          state_d = LS_IDLE;
        end
      end
      LS_WAIT: begin
        cnt_d = cnt_inc;
        if (in_mem_resp_valid) begin
          state_d = in_flush ? LS_IDLE : LS_RESP;
          value_d = is_store ? '0 : in_mem_rdata;
          fault_d = 1'b0;
        end else if (timed_out) begin
          state_d = in_flush ? LS_IDLE : LS_RESP;
          value_d = '0;
          fault_d = 1'b1;
        end else if (in_flush) begin
          state_d = LS_DRAIN;
        end
      end
      LS_DRAIN: begin
        cnt_d = cnt_inc;
        if (in_mem_resp_valid || timed_out) begin
          state_d = LS_IDLE;
        end
      end
      LS_RESP: begin
        state_d = LS_IDLE;
      end
      default: begin
        state_d = LS_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= LS_IDLE;
      cnt_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= 1'b1;
    end
  end

  // Payload registers are only observed through state-gated outputs.
  always_ff @(posedge in_clk) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    tag_q   <= tag_d;
    value_q <= value_d;
    fault_q <= fault_d;
  end

  always_comb begin
    req_vld = (state_q == LS_REQ);
    done    = (state_q == LS_RESP) && !in_flush;

    out_rs_ready          = rs_ready;
    out_mem_req_valid     = req_vld;
    out_mem_we            = req_vld && is_store;
    out_mem_addr          = req_vld ? addr_q : '0;
    out_mem_wdata         = (req_vld && is_store) ? wdata_q : '0;
    out_rob_done          = done;
    out_rob_dst_rob_index = done ? tag_q : '0;
    out_rob_value         = done ? value_q : '0;
    out_rob_fault         = done && fault_q;
  end

endmodule

// File: doc/ls_unit.md
LS_UNIT -- requirements
Module: ls_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max cycles waited for memory response before fault.
REQ-002 in_clk  input  1  sole clock, all state updates on rising edge.
REQ-003 in_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_rs_start  input  1  RS issues an entry this cycle.
REQ-005 in_rs_op  input  fu_op_t  FU_OP_LDUR or FU_OP_STUR.
REQ-006 in_rs_val_a  input  GPR_SIZE  effective address (base+offset already summed by RS).
REQ-007 in_rs_val_b  input  GPR_SIZE  store data (ignored for loads).
REQ-008 in_rs_dst_rob_index  input  ROB_IDX_SIZE  ROB tag of the op.
REQ-009 out_rs_ready  output  1  unit can accept an issue.
REQ-010 out_mem_req_valid / in_mem_req_ready  output/input  1/1  memory request handshake.
REQ-011 out_mem_we  output  1  1=store, 0=load; out_mem_addr output GPR_SIZE; out_mem_wdata output GPR_SIZE.
REQ-012 in_mem_resp_valid  input  1  memory completion (load data or store ack); in_mem_rdata input GPR_SIZE.
REQ-013 in_flush  input  1  mispredict flush, abandon in-flight op.
REQ-014 out_rob_done  output  1  one-cycle result pulse; out_rob_dst_rob_index ROB_IDX_SIZE; out_rob_value GPR_SIZE; out_rob_fault 1.

Function
REQ-015 States SHALL be IDLE, REQ, WAIT, RESP, DRAIN; out_rs_ready SHALL be 1 only in IDLE with in_flush low.
REQ-016 Accept = in_rs_start & out_rs_ready at edge; op, address, data, tag SHALL be captured; issue ignored when not ready.
REQ-017 On accept with in_rs_val_a[2:0] != 0: no memory request, next state RESP with fault=1, value=0.
REQ-018 On aligned accept: next state REQ; out_mem_req_valid=1, addr/we/wdata from captured regs, held stable until in_mem_req_ready.
REQ-019 REQ & in_mem_req_ready -> WAIT; timeout counter cleared to 0.
REQ-020 WAIT: counter increments each cycle; in_mem_resp_valid -> RESP, capture rdata for loads, 0 for stores; counter reaching TIMEOUT_CYCLES -> RESP with fault=1, value=0.
REQ-021 RESP: out_rob_done=1 for exactly one cycle with captured tag/value/fault, then IDLE.
REQ-022 Latency: accept at edge N, req_valid in N+1; with req_ready in N+1 and resp_valid in N+2, done asserts in N+3.
REQ-023 in_flush in REQ (request not yet accepted) or RESP -> IDLE, no done pulse; in WAIT -> DRAIN.
REQ-024 DRAIN: waits for in_mem_resp_valid (or timeout), discards it, -> IDLE, no done pulse; in_flush in IDLE blocks accept that cycle.
REQ-025 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); no wrap beyond TIMEOUT_CYCLES.
REQ-026 Outputs other than done SHALL be 0 when their valid is low.

Reset
REQ-027 in_rst_n low SHALL immediately force IDLE, counter 0, all outputs 0 except out_rs_ready, which is 0 during reset and 1 from the first edge after release.
REQ-028 Reset mid-operation SHALL drop the op silently; a later memory response SHALL be ignored in IDLE.

Structure
REQ-029 fu_op_t, GPR_SIZE, ROB_IDX_SIZE SHALL come from the shared data_structures package; ls_state_t enum SHALL be added there.
REQ-030 Single module, no sub-modules.

Verification
REQ-031 Load: issue LDUR addr 0x40 tag 5, req_ready immediately, resp rdata 0x1234 next cycle -> done at N+3, tag 5, value 0x1234, fault 0.
REQ-032 Store: STUR addr 0x80 data 0xDEAD, req_ready held low 3 cycles -> req stable 4 cycles, we=1, wdata 0xDEAD; done value 0.
REQ-033 Misaligned: LDUR addr 0x43 -> no req_valid, done at N+1 with fault 1.
REQ-034 Flush in WAIT: flush, then resp after 2 cycles -> no done pulse, ready returns after resp.
REQ-035 Timeout: TIMEOUT_CYCLES=4, no resp -> done with fault 1 exactly 4 cycles after WAIT entry.
REQ-036 Async reset in WAIT -> outputs 0 without clock edge; late resp_valid produces no done.
